alu_pipe_param: RTL and testbench
=================================

// Module: alu_pipe_param
// PURPOSE
//   Parametrised-width ALU with valid/ready handshakes on input and output.
//   Extends the 32-bit AND/OR/XOR/ADD/SUB ALU with signed/unsigned compare,
//   shifts, an iterative shift-add multiply, and a full flag set (C/V/Z/N).
//   Sits between the operand/issue stage and the writeback stage of the datapath.
//   Single-cycle ops sustain one result per cycle. MUL occupies the unit for WIDTH cycles.
// PARAMETERS
//   WIDTH   32  operand/result width; power of 2, >= 4; SHW = $clog2(WIDTH)
//   MUL_EN  1   1: sel 1010 is MUL; 0: sel 1010 is treated as undefined
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/sel valid
//   in_ready   out  1      unit can accept; transfer when in_valid && in_ready
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//   sel        in   4      operation select
//   out_valid  out  1      out/flags valid
//   out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//   out        out  WIDTH  result
//   carry      out  1      carry / not-borrow / MUL high-half nonzero
//   overflow   out  1      signed overflow (ADD/SUB only)
//   zero       out  1      out == 0
//   negative   out  1      out[WIDTH-1]
// BEHAVIOUR
//   Reset: state IDLE, out_valid=0, out=0, carry=overflow=zero=negative=0, multiplier regs cleared.
//   Rst wins over every other event, including mid-MUL (operation is discarded, no output).
//   Ops: 0000 AND | 0001 OR | 0010 XOR | 0011 ADD | 0100 SUB (a + ~b + 1) | 0101 SLT signed (0/1)
//     0110 SLTU (0/1) | 0111 SLL | 1000 SRL | 1001 SRA | 1010 MUL (low WIDTH bits, unsigned)
//     others: out=0, carry=overflow=0, zero=1, negative=0
//   Flags: ADD carry = carry-out of bit WIDTH-1; SUB carry = 1 iff a >= b unsigned.
//     overflow ADD = a[msb]==b[msb] && out[msb]!=a[msb]; SUB = a[msb]!=b[msb] && out[msb]!=a[msb].
//     overflow=0 for all other ops. carry=0 for logic/compare/shift ops.
//     zero and negative are computed from the registered out for every op.
//   All flags are registered together with out; they are never computed from a stale out.
//   FSM IDLE / MUL:
//     in_ready = (state==IDLE) && (!out_valid || out_ready).
//     IDLE, accept, non-MUL: out/flags written at the accepting edge; out_valid=1 next cycle (latency 1).
//     IDLE, accept, MUL: latch a, b; clear acc and cnt; go MUL; out_valid cleared if its result was taken.
//     MUL: each edge, if mb[0] then acc += ma (2*WIDTH-bit acc); ma <<= 1; mb >>= 1; cnt++.
//       After WIDTH iterations: write out = acc[WIDTH-1:0], carry = |acc[2W-1:W]; set out_valid;
//       go IDLE. out_valid is first visible WIDTH cycles after the accept edge.
//     in_ready=0 throughout MUL; in_valid is ignored there.
//   Output hold: while out_valid && !out_ready, out and flags stay stable and in_ready=0.
//   Simultaneous out transfer and in accept in the same cycle: new result replaces old;
//     out_valid stays 1 (no bubble).
//   out_valid drops to 0 on out transfer when no new result is written that edge.
//   Shifts use b[SHW-1:0] only; upper bits of b are ignored. SRA replicates a[msb].
// TESTING (WIDTH=32, MUL_EN=1)
//   ADD a=0x7FFFFFFF b=1 -> next cycle out=0x80000000, V=1, C=0, N=1, Z=0, out_valid=1
//   SUB 5-7 -> out=0xFFFFFFFE, C=0, V=0, N=1; SUB 7-5 -> out=2, C=1; SLT 0xFFFFFFFF,1 -> 1; SLTU -> 0
//   SRA 0x80000000 by 4 -> 0xF8000000; SLL 1 by b=35 -> 8 (b[4:0]=3); sel=1111 -> out=0, Z=1
//   MUL 0x10000*0x10000 -> out_valid exactly 32 cycles after accept, out=0, C=1, Z=1;
//     in_ready=0 throughout; MUL 3*5 -> 15, C=0
//   4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles;
//     out_ready=0 for 3 cycles -> out held, in_ready=0
//   rst pulsed 10 cycles into MUL -> next cycle out_valid=0, in_ready=1, all flags 0, no late result

Source files
------------

// File: rtl/alu_pipe_param.sv
// alu_pipe_param
//   Parametrised-width ALU between the operand/issue stage and writeback.
//   Single-cycle ops (logic, add/sub, compares, shifts) give one result per
//   cycle; MUL is an iterative shift-add multiply that holds the unit for
//   WIDTH cycles. Result and flags are registered together.
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake for a, b, sel
//   a, b            operands (shift amount = b[SHW-1:0])
//   sel             operation select
//   out_valid/ready output handshake for out and flags
//   out             result
//   carry           carry / not-borrow / MUL high half nonzero
//   overflow        signed overflow (ADD/SUB)
//   zero, negative  out == 0, out[WIDTH-1]
module alu_pipe_param #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_t;

  // Single-cycle operations. Unknown selects (and MUL, which is handled by
  // the iterative path) evaluate to all zeros.
  function automatic alu_t alu_eval(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic [3:0]       op);
    alu_t                    r;
    logic [WIDTH:0]          sum;
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [SHW-1:0]          sh;
    r   = '0;
    sum = '0;
    xs  = x;
    ys  = y;
    sh  = y[SHW-1:0];
    case (op)
      OP_AND: r.res = x & y;
      OP_OR:  r.res = x | y;
      OP_XOR: r.res = x ^ y;
      OP_ADD: begin
        sum   = {1'b0, x} + {1'b0, y};
        r.res = sum[WIDTH-1:0];
        r.c   = sum[WIDTH];
        r.v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // a + ~b + 1: the carry out is the not-borrow (a >= b unsigned)
        sum   = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        r.res = sum[WIDTH-1:0];
        r.c   = sum[WIDTH];
        r.v   = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, (xs < ys)};
      OP_SLTU: r.res = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLL:  r.res = x << sh;
      OP_SRL:  r.res = x >> sh;
      OP_SRA:  r.res = xs >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t               state;
  state_t               state_nx;
  alu_t                 alu_p0;
  logic                 is_mul_p0;
  logic                 accept;
  logic                 mul_last;
  logic                 wr_en;
  logic [WIDTH-1:0]     res_wr;
  logic                 c_wr;
  logic                 v_wr;
  logic [2*WIDTH-1:0]   ma;
  logic [WIDTH-1:0]     mb;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [SHW-1:0]       cnt;

  // ---- stage p0: operand decode and single-cycle evaluation ----
  always_comb begin
    alu_p0    = alu_eval(a, b, sel);
    is_mul_p0 = MUL_EN && (sel == OP_MUL);
    in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    acc_nx    = acc + (mb[0] ? ma : '0);
    mul_last  = (state == ST_MUL) && (cnt == SHW'(WIDTH - 1));

    wr_en  = 1'b0;
    res_wr = alu_p0.res;
    c_wr   = alu_p0.c;
    v_wr   = alu_p0.v;
    if (accept && !is_mul_p0) begin
      wr_en = 1'b1;
    end
    if (mul_last) begin
      wr_en  = 1'b1;
      res_wr = acc_nx[WIDTH-1:0];
      c_wr   = |acc_nx[2*WIDTH-1:WIDTH];
      v_wr   = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && is_mul_p0) state_nx = ST_MUL;
      ST_MUL:  if (mul_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ---- stage p1: iterative shift-add multiplier ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (accept && is_mul_p0) begin
        ma  <= {{WIDTH{1'b0}}, a};
        mb  <= b;
        acc <= '0;
        cnt <= '0;
      end
    end else begin
      acc <= acc_nx;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  // ---- output register: result and all flags written together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        out      <= res_wr;
        carry    <= c_wr;
        overflow <= v_wr;
        zero     <= (res_wr == '0);
        negative <= res_wr[WIDTH-1];
      end
      // A write while the old result is being taken keeps valid high.
      if (wr_en)                       out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param
//   Bench for alu_pipe_param (WIDTH=32, MUL_EN=1). A transaction-level model
//   predicts handshake state and results every cycle; directed cases pin
//   known values; random traffic covers the rest.
module tb_alu_pipe_param;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out;
  logic          carry, overflow, zero, negative;

  always #5 clk = ~clk;

  alu_pipe_param #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .overflow(overflow), .zero(zero),
    .negative(negative)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] out;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  // Reference results from plain wide arithmetic.
  function automatic res_t ref_op(input logic [31:0] x, input logic [31:0] y,
                                  input logic [3:0] op);
    res_t        r;
    longint      sx, sy, s;
    logic [63:0] p;
    int          xi;
    int          sh;
    r  = '0;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[4:0]);
    case (op)
      4'd0: r.out = x & y;
      4'd1: r.out = x | y;
      4'd2: r.out = x ^ y;
      4'd3: begin
        p = 64'(x) + 64'(y);
        r.out = p[31:0];
        r.c = p[32];
        s = sx + sy;
        r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: begin
        r.out = x - y;
        r.c = (x >= y);
        s = sx - sy;
        r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: r.out = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r.out = (x < y) ? 32'd1 : 32'd0;
      4'd7: r.out = x << sh;
      4'd8: r.out = x >> sh;
      4'd9: begin xi = $signed(x); xi = xi >>> sh; r.out = xi; end
      4'd10: begin
        p = 64'(x) * 64'(y);
        r.out = p[31:0];
        r.c = (p[63:32] != 0);
      end
      default: r.out = '0;
    endcase
    r.z = (r.out == 0);
    r.n = r.out[31];
    return r;
  endfunction

  // Model state: what the outputs must show after the next rising edge.
  res_t m_res = '0;
  res_t m_pend = '0;
  res_t m_tmp;
  logic m_valid = 1'b0;
  logic m_rdy;
  int   m_busy = 0;
  bit   armed = 1'b0;

  always @(negedge clk) begin
    m_rdy = (m_busy == 0) && (!m_valid || out_ready);
    if (armed) begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("result", {out, carry, overflow, zero, negative}, m_res);
    end
    if (rst) begin
      m_valid = 1'b0;
      m_busy  = 0;
      m_res   = '0;
      armed   = 1'b1;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1;
        m_res   = m_pend;
      end
    end else if (in_valid && m_rdy) begin
      m_tmp = ref_op(a, b, sel);
      if (sel == 4'd10) begin
        m_busy  = W;
        m_pend  = m_tmp;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_res   = m_tmp;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Issue one op and wait for its result; wait = edges after the accept edge
  // until out_valid is seen. Called and returns at posedge+1.
  task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] op, input logic [31:0] e_out,
                       input logic [3:0] e_f, input int e_wait);
    int n;
    int wt;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; a = x; b = y; sel = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wt = 0;
    while (!out_valid && wt < 100) begin @(posedge clk); #1; wt++; end
    chk({name, "_wait"}, wt, e_wait);
    chk({name, "_out"}, out, e_out);
    chk({name, "_flags"}, {carry, overflow, zero, negative}, e_f);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  bit saw;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_flags", {out, carry, overflow, zero, negative}, 37'h0);

    // flags order {carry, overflow, zero, negative}
    do_op("add_ovf",  32'h7FFF_FFFF, 32'd1, 4'd3, 32'h8000_0000, 4'b0101, 0);
    do_op("sub_5_7",  32'd5, 32'd7, 4'd4, 32'hFFFF_FFFE, 4'b0001, 0);
    do_op("sub_7_5",  32'd7, 32'd5, 4'd4, 32'd2, 4'b1000, 0);
    do_op("slt",      32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, 4'b0000, 0);
    do_op("sltu",     32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0, 4'b0010, 0);
    do_op("sra",      32'h8000_0000, 32'd4, 4'd9, 32'hF800_0000, 4'b0001, 0);
    do_op("sll_b35",  32'd1, 32'd35, 4'd7, 32'd8, 4'b0000, 0);
    do_op("srl",      32'h8000_0000, 32'd31, 4'd8, 32'd1, 4'b0000, 0);
    do_op("and",      32'h0000_F0F0, 32'h0000_0FF0, 4'd0, 32'h0000_00F0, 4'b0000, 0);
    do_op("undef",    32'h1234_5678, 32'h9, 4'd15, 32'd0, 4'b0010, 0);
    do_op("mul_big",  32'h0001_0000, 32'h0001_0000, 4'd10, 32'd0, 4'b1010, 32);
    do_op("mul_3_5",  32'd3, 32'd5, 4'd10, 32'd15, 4'b0000, 32);

    // Back-to-back ADDs: one result per cycle.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 32'(i); b = 32'(i * 10); sel = 4'd3;
      @(posedge clk); #1;
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_out", out, 32'(i * 11));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", out_valid, 1'b0);

    // Output hold with a pending op, then simultaneous take + accept.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd100; b = 32'd1; sel = 4'd3;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_out", out, 32'd101);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("swap_valid", out_valid, 1'b1);
    chk("swap_out", out, 32'd10);
    @(posedge clk); #1;
    chk("swap_drain", out_valid, 1'b0);

    // Reset ten cycles into a multiply.
    in_valid = 1'b1; a = 32'd3; b = 32'd5; sel = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mulrst_valid", out_valid, 1'b0);
    chk("mulrst_in_ready", in_ready, 1'b1);
    chk("mulrst_flags", {out, carry, overflow, zero, negative}, 37'h0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    chk("mulrst_no_late", saw, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      sel       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
